// File: rtl/csel_addsub_pipe.sv
// csel_addsub_pipe
//
// Pipelined carry-select adder/subtractor with ALU flags.
// The WIDTH-bit operation is split into NB = WIDTH/BLOCK groups. Each group
// computes two sums: one with carry-in 0 and one with carry-in 1. The carry
// coming out of the previous group picks one of them.
// The groups are spread over L = ceil(NB/BPS) register stages. Stage k
// resolves groups k*BPS .. min((k+1)*BPS, NB)-1. Operand slices that are not
// yet resolved are skewed forward alongside the partial result.
// All stages advance together under one valid/ready handshake.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operand beat present
//   in_ready   beat can be accepted this cycle (combinational from out_ready)
//   a, b       WIDTH-bit two's-complement operands
//   cin        carry (ADC) / borrow (SBB) input
//   op         00 ADD, 01 ADC, 10 SUB, 11 SBB
//   out_valid  result beat present
//   out_ready  consumer takes the result this cycle
//   sum        WIDTH-bit result
//   c, v, z, n carry out of MSB, signed overflow, zero, negative
//
// WIDTH must be a multiple of BLOCK.

module csel_addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4,
  parameter int BPS   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c,
  output logic             v,
  output logic             z,
  output logic             n
);

  localparam int NB = WIDTH / BLOCK;
  localparam int L  = (NB + BPS - 1) / BPS;

  // Per-stage registers. Stage L-1 is the output stage.
  logic [L-1:0]     vld_q, vld_d;
  logic [L-1:0]     cy_q, cy_d;
  logic [WIDTH-1:0] a_q   [L];
  logic [WIDTH-1:0] a_d   [L];
  logic [WIDTH-1:0] bp_q  [L];
  logic [WIDTH-1:0] bp_d  [L];
  logic [WIDTH-1:0] sum_q [L];
  logic [WIDTH-1:0] sum_d [L];
  logic             v_q, v_d;
  logic             z_q, z_d;
  logic             n_q, n_d;

  logic             en;
  logic [WIDTH-1:0] bp_in;
  logic             c0;

  // Working values while one stage is being evaluated.
  logic             st_vld;
  logic             st_cy;
  logic [WIDTH-1:0] st_a;
  logic [WIDTH-1:0] st_bp;
  logic [WIDTH-1:0] st_sum;
  logic [BLOCK:0]   blk_lo;
  logic [BLOCK:0]   blk_hi;

  // One global advance: the whole pipe either moves or holds.
  assign en       = !vld_q[L-1] || out_ready;
  assign in_ready = en;

  // Effective B operand and carry-in.
  // SBB takes cin as a borrow, so the adder's carry-in is its inverse.
  always_comb begin
    bp_in = op[1] ? ~b : b;
    case (op)
      2'b00:   c0 = 1'b0;
      2'b01:   c0 = cin;
      2'b10:   c0 = 1'b1;
      default: c0 = ~cin;
    endcase
  end

  always_comb begin
    st_vld = 1'b0;
    st_cy  = 1'b0;
    st_a   = '0;
    st_bp  = '0;
    st_sum = '0;
    blk_lo = '0;
    blk_hi = '0;
    vld_d  = '0;
    cy_d   = '0;
    v_d    = 1'b0;
    z_d    = 1'b0;
    n_d    = 1'b0;
    for (int k = 0; k < L; k++) begin
      a_d[k]   = '0;
      bp_d[k]  = '0;
      sum_d[k] = '0;
    end

    for (int k = 0; k < L; k++) begin
      if (k == 0) begin
        st_vld = in_valid;
        st_a   = a;
        st_bp  = bp_in;
        st_sum = '0;
        st_cy  = c0;
      end else begin
        st_vld = vld_q[k-1];
        st_a   = a_q[k-1];
        st_bp  = bp_q[k-1];
        st_sum = sum_q[k-1];
        st_cy  = cy_q[k-1];
      end

      // Both group sums are formed independently of the incoming carry.
      // The carry only drives the select, so no ripple crosses a group.
      for (int j = 0; j < BPS; j++) begin
        if (k * BPS + j < NB) begin
          blk_lo = {1'b0, st_a[(k*BPS+j)*BLOCK +: BLOCK]}
                 + {1'b0, st_bp[(k*BPS+j)*BLOCK +: BLOCK]};
          blk_hi = {1'b0, st_a[(k*BPS+j)*BLOCK +: BLOCK]}
                 + {1'b0, st_bp[(k*BPS+j)*BLOCK +: BLOCK]}
                 + {{BLOCK{1'b0}}, 1'b1};
          if (st_cy) begin
            st_sum[(k*BPS+j)*BLOCK +: BLOCK] = blk_hi[BLOCK-1:0];
            st_cy                            = blk_hi[BLOCK];
          end else begin
            st_sum[(k*BPS+j)*BLOCK +: BLOCK] = blk_lo[BLOCK-1:0];
            st_cy                            = blk_lo[BLOCK];
          end
        end
      end

      vld_d[k] = st_vld;
      a_d[k]   = st_a;
      bp_d[k]  = st_bp;
      sum_d[k] = st_sum;
      cy_d[k]  = st_cy;

      if (k == L - 1) begin
        v_d = (st_a[WIDTH-1] == st_bp[WIDTH-1]) && (st_sum[WIDTH-1] != st_a[WIDTH-1]);
        z_d = ~|st_sum;
        n_d = st_sum[WIDTH-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      cy_q  <= '0;
      v_q   <= 1'b0;
      z_q   <= 1'b0;
      n_q   <= 1'b0;
      for (int k = 0; k < L; k++) begin
        a_q[k]   <= '0;
        bp_q[k]  <= '0;
        sum_q[k] <= '0;
      end
    end else if (en) begin
      vld_q <= vld_d;
      cy_q  <= cy_d;
      v_q   <= v_d;
      z_q   <= z_d;
      n_q   <= n_d;
      for (int k = 0; k < L; k++) begin
        a_q[k]   <= a_d[k];
        bp_q[k]  <= bp_d[k];
        sum_q[k] <= sum_d[k];
      end
    end
  end

  assign out_valid = vld_q[L-1];
  assign sum       = sum_q[L-1];
  assign c         = cy_q[L-1];
  assign v         = v_q;
  assign z         = z_q;
  assign n         = n_q;

endmodule

// File: tb/tb_csel_addsub_pipe.sv
// Bench for csel_addsub_pipe. Two instances run side by side on one clock:
// index 0 uses the defaults (16/4/2, latency 2), and index 1 uses 32/8/1
// (latency 4). A reference model holds one slot per pipeline stage. It
// advances whenever the handshake says the pipe moves, and each beat's
// expected result is computed as plain integer arithmetic a + b' + c0.

module tb_csel_addsub_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_t  [2];
  logic        iv_t   [2];
  logic        ordy_t [2];
  logic        cin_t  [2];
  logic [1:0]  op_t   [2];
  logic [31:0] a_t    [2];
  logic [31:0] b_t    [2];

  logic        ir  [2];
  logic        ov  [2];
  logic        c_o [2];
  logic        v_o [2];
  logic        z_o [2];
  logic        n_o [2];
  logic [15:0] sum0;
  logic [31:0] sum1;

  csel_addsub_pipe dut0 (
    .clk(clk), .rst(rst_t[0]), .in_valid(iv_t[0]), .in_ready(ir[0]),
    .a(a_t[0][15:0]), .b(b_t[0][15:0]), .cin(cin_t[0]), .op(op_t[0]),
    .out_valid(ov[0]), .out_ready(ordy_t[0]), .sum(sum0),
    .c(c_o[0]), .v(v_o[0]), .z(z_o[0]), .n(n_o[0])
  );

  csel_addsub_pipe #(.WIDTH(32), .BLOCK(8), .BPS(1)) dut1 (
    .clk(clk), .rst(rst_t[1]), .in_valid(iv_t[1]), .in_ready(ir[1]),
    .a(a_t[1]), .b(b_t[1]), .cin(cin_t[1]), .op(op_t[1]),
    .out_valid(ov[1]), .out_ready(ordy_t[1]), .sum(sum1),
    .c(c_o[1]), .v(v_o[1]), .z(z_o[1]), .n(n_o[1])
  );

  typedef struct packed {
    logic        vld;
    logic [31:0] s;
    logic        c;
    logic        ov;
    logic        z;
    logic        n;
  } beat_t;

  beat_t pipe [2][4];
  int n_checks = 0;
  int n_fail   = 0;
  int acc_m    [2];
  int xfer_m   [2];
  int xfer_dut [2];

  function automatic int lat(int d);
    return (d == 0) ? 2 : 4;
  endfunction

  function automatic int wid(int d);
    return (d == 0) ? 16 : 32;
  endfunction

  function automatic logic [31:0] get_sum(int d);
    return (d == 0) ? {16'h0, sum0} : sum1;
  endfunction

  function automatic logic [35:0] get_res(int d);
    return {get_sum(d), c_o[d], v_o[d], z_o[d], n_o[d]};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t refm(int d, logic [31:0] a, logic [31:0] b, logic cin, logic [1:0] op);
    beat_t  r;
    longint w, mask, half, ua, ub, c0, tot, sa, sb, st;
    w    = wid(d);
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(a) & mask;
    ub   = (op[1] ? longint'(~b) : longint'(b)) & mask;
    case (op)
      2'd0:    c0 = 0;
      2'd1:    c0 = cin ? 1 : 0;
      2'd2:    c0 = 1;
      default: c0 = cin ? 0 : 1;
    endcase
    tot  = ua + ub + c0;
    sa   = (ua >= half) ? ua - (mask + 1) : ua;
    sb   = (ub >= half) ? ub - (mask + 1) : ub;
    st   = sa + sb + c0;
    r.vld = 1'b0;
    r.s   = 32'(tot & mask);
    r.c   = ((tot >> w) & 1) != 0;
    r.ov  = (st >= half) || (st < -half);
    r.z   = (tot & mask) == 0;
    r.n   = ((tot >> (w - 1)) & 1) != 0;
    return r;
  endfunction

  // One clock: check in_ready, advance the model at the edge, then check outputs.
  task automatic cycle();
    logic en_m   [2];
    logic was_rst[2];
    int   ll;
    #1;
    for (int d = 0; d < 2; d++) begin
      en_m[d] = !pipe[d][lat(d)-1].vld || ordy_t[d];
      chk($sformatf("in_ready_d%0d", d), 64'(ir[d]), 64'(en_m[d]));
      if (ov[d] && ordy_t[d] && !rst_t[d]) xfer_dut[d]++;
      was_rst[d] = rst_t[d];
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      ll = lat(d);
      if (rst_t[d]) begin
        for (int i = 0; i < 4; i++) pipe[d][i] = '0;
      end else if (en_m[d]) begin
        if (pipe[d][ll-1].vld && ordy_t[d]) xfer_m[d]++;
        for (int i = 3; i > 0; i--) if (i < ll) pipe[d][i] = pipe[d][i-1];
        pipe[d][0]     = refm(d, a_t[d], b_t[d], cin_t[d], op_t[d]);
        pipe[d][0].vld = iv_t[d];
        if (iv_t[d]) acc_m[d]++;
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      ll = lat(d);
      chk($sformatf("out_valid_d%0d", d), 64'(ov[d]), 64'(pipe[d][ll-1].vld));
      if (pipe[d][ll-1].vld)
        chk($sformatf("result_d%0d", d), 64'(get_res(d)),
            64'({pipe[d][ll-1].s, pipe[d][ll-1].c, pipe[d][ll-1].ov, pipe[d][ll-1].z, pipe[d][ll-1].n}));
      if (was_rst[d])
        chk($sformatf("reset_outputs_d%0d", d), 64'(get_res(d)), 64'(0));
    end
  endtask

  task automatic idle_all();
    for (int d = 0; d < 2; d++) begin
      iv_t[d]   = 1'b0;
      ordy_t[d] = 1'b1;
      rst_t[d]  = 1'b0;
    end
  endtask

  task automatic directed(int d, string tag, logic [1:0] op, logic [31:0] a, logic [31:0] b,
                          logic cin, logic [31:0] es, logic ec, logic ev, logic ez, logic en_);
    int k;
    idle_all();
    iv_t[d] = 1'b1; op_t[d] = op; a_t[d] = a; b_t[d] = b; cin_t[d] = cin;
    cycle();
    iv_t[d] = 1'b0;
    k = 1;
    while (!ov[d] && k < 12) begin
      cycle();
      k++;
    end
    chk({tag, "_latency"}, 64'(k), 64'(lat(d)));
    chk(tag, 64'(get_res(d)), 64'({es, ec, ev, ez, en_}));
  endtask

  initial begin
    int sent [2];
    int base [2];
    int xb   [2];
    int cyc;

    for (int d = 0; d < 2; d++) begin
      rst_t[d] = 1'b1; iv_t[d] = 1'b1; ordy_t[d] = 1'b1;
      a_t[d] = $urandom; b_t[d] = $urandom; cin_t[d] = 1'b0; op_t[d] = 2'd0;
      acc_m[d] = 0; xfer_m[d] = 0; xfer_dut[d] = 0;
      for (int i = 0; i < 4; i++) pipe[d][i] = '0;
    end

    // Reset with beats presented: none may be accepted.
    repeat (2) @(posedge clk);
    cycle();
    for (int d = 0; d < 2; d++) begin
      rst_t[d] = 1'b0; iv_t[d] = 1'b0; ordy_t[d] = 1'b0;
    end
    cycle();
    chk("no_accept_in_reset", 64'(acc_m[0] + acc_m[1]), 64'(0));

    // Directed values with hand-derived results.
    directed(0, "add_7fff_1",  2'd0, 32'h7FFF, 32'h0001, 1'b0, 32'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
    directed(0, "sub_5_5",     2'd2, 32'h0005, 32'h0005, 1'b0, 32'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    directed(0, "sbb_0_1",     2'd3, 32'h0000, 32'h0001, 1'b1, 32'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
    directed(0, "adc_ffff_0",  2'd1, 32'hFFFF, 32'h0000, 1'b1, 32'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    directed(0, "add_8000_x2", 2'd0, 32'h8000, 32'h8000, 1'b0, 32'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
    directed(1, "w32_add_ovf", 2'd0, 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    directed(1, "w32_sub_neg", 2'd2, 32'h0, 32'h1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_all();
    repeat (5) cycle();

    // Back-pressure: three beats with out_ready low for five cycles.
    for (int d = 0; d < 2; d++) begin
      sent[d] = 0; base[d] = acc_m[d]; xb[d] = xfer_dut[d];
    end
    for (int t = 0; t < 20; t++) begin
      for (int d = 0; d < 2; d++) begin
        ordy_t[d] = (t >= 5);
        iv_t[d]   = (acc_m[d] - base[d]) < 3;
        if (acc_m[d] - base[d] != sent[d] || t == 0) begin
          a_t[d] = $urandom; b_t[d] = $urandom;
          op_t[d] = 2'($urandom_range(0, 3)); cin_t[d] = 1'($urandom_range(0, 1));
          sent[d] = acc_m[d] - base[d];
        end
      end
      cycle();
    end
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("bp_accepted_d%0d", d), 64'(acc_m[d] - base[d]), 64'(3));
      chk($sformatf("bp_delivered_d%0d", d), 64'(xfer_dut[d] - xb[d]), 64'(3));
    end

    // Reset with two beats in flight: neither may emerge.
    idle_all();
    for (int d = 0; d < 2; d++) ordy_t[d] = 1'b0;
    for (int t = 0; t < 2; t++) begin
      for (int d = 0; d < 2; d++) begin
        iv_t[d] = 1'b1; a_t[d] = $urandom; b_t[d] = $urandom; op_t[d] = 2'd0;
      end
      cycle();
    end
    for (int d = 0; d < 2; d++) begin
      rst_t[d] = 1'b1; xb[d] = xfer_dut[d];
    end
    cycle();
    for (int d = 0; d < 2; d++) chk($sformatf("rst_out_valid_d%0d", d), 64'(ov[d]), 64'(0));
    idle_all();
    repeat (6) cycle();
    for (int d = 0; d < 2; d++)
      chk($sformatf("rst_discard_d%0d", d), 64'(xfer_dut[d] - xb[d]), 64'(0));

    // Random stream: 1000 beats per instance with random valid/ready.
    for (int d = 0; d < 2; d++) base[d] = acc_m[d];
    cyc = 0;
    while (((acc_m[0] - base[0]) < 1000 || (acc_m[1] - base[1]) < 1000) && cyc < 20000) begin
      for (int d = 0; d < 2; d++) begin
        iv_t[d]   = ($urandom_range(0, 3) != 0) && ((acc_m[d] - base[d]) < 1000);
        ordy_t[d] = ($urandom_range(0, 3) != 0);
        a_t[d]    = $urandom;
        b_t[d]    = $urandom;
        if ($urandom_range(0, 7) == 0) a_t[d] = 32'hFFFF_FFFF;
        if ($urandom_range(0, 7) == 0) b_t[d] = 32'h0;
        op_t[d]   = 2'($urandom_range(0, 3));
        cin_t[d]  = 1'($urandom_range(0, 1));
      end
      cycle();
      cyc++;
    end
    for (int d = 0; d < 2; d++)
      chk($sformatf("rand_accepted_d%0d", d), 64'(acc_m[d] - base[d]), 64'(1000));
    idle_all();
    repeat (8) cycle();
    for (int d = 0; d < 2; d++)
      chk($sformatf("transfer_count_d%0d", d), 64'(xfer_dut[d]), 64'(xfer_m[d]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
